s3g_rx: RTL

- Receive-side framer for the S3G link. It sits between the UART receiver and the command decoder, acting as the counterpart to the packet transmitter.
- Parses the byte stream: 0xD5 start, length, payload, CRC8.
- Checks the length and the CRC, then presents a validated payload as 16 parallel byte outputs plus a one-cycle packet strobe.
- Bad or truncated packets are dropped without disturbing the last good payload.

---
 rtl/s3g_rx.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/s3g_rx.sv
// s3g_rx - receive-side framer for the S3G link.
// Frame format: 0xD5 start, length, payload (0..MAX_LEN bytes), CRC8 over payload.
// A frame with a good CRC is latched onto payload_len/buf0..buf15 with a one-cycle
// packet_valid strobe. Bad or oversized frames are dropped and signalled with
// err_crc/err_len, and the last good payload is left untouched.
// Optional feature macro: S3G_RX_TIMEOUT_EN enables the inter-byte gap timeout
// (err_timeout). Without it err_timeout is tied low and a stalled frame waits.
module s3g_rx #(
  parameter int MAX_LEN        = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       packet_valid,
  output logic [7:0] payload_len,
  output logic [7:0] buf0,
  output logic [7:0] buf1,
  output logic [7:0] buf2,
  output logic [7:0] buf3,
  output logic [7:0] buf4,
  output logic [7:0] buf5,
  output logic [7:0] buf6,
  output logic [7:0] buf7,
  output logic [7:0] buf8,
  output logic [7:0] buf9,
  output logic [7:0] buf10,
  output logic [7:0] buf11,
  output logic [7:0] buf12,
  output logic [7:0] buf13,
  output logic [7:0] buf14,
  output logic [7:0] buf15,
  output logic       busy,
  output logic       err_crc,
  output logic       err_len,
  output logic       err_timeout
);

  localparam int         DEPTH     = 16;
  localparam logic [7:0] SOF_BYTE  = 8'hD5;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  // Elaboration-time parameter sanity checks.
  if ((MAX_LEN < 1) || (MAX_LEN > DEPTH)) begin : g_bad_max_len
    $error("s3g_rx: MAX_LEN must be in 1..16");
  end
  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES >= (1 << 24))) begin : g_bad_timeout
    $error("s3g_rx: TIMEOUT_CYCLES must be in 1..2^24-1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LEN  = 2'd1,
    S_DATA = 2'd2,
    S_CRC  = 2'd3
  } state_t;

  // CRC8, polynomial x^8+x^2+x+1 (0x07), MSB first, one data byte per call.
  // Bit-identical to the transmitter's nextCRC8_D8.
  function automatic logic [7:0] next_crc8_d8(input logic [7:0] data, input logic [7:0] crc);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ 8'h07;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

  state_t     state_q;
  logic [7:0] len_q;
  logic [3:0] byte_cnt_q;
  logic [7:0] crc_q;
  logic [7:0] crc_d;
  logic [7:0] staging_q [DEPTH];
  logic [7:0] buf_q     [DEPTH];
  logic [7:0] payload_len_q;
  logic       packet_valid_q;
  logic       busy_q;
  logic       err_crc_q;
  logic       err_len_q;
  logic       err_timeout_q;
  logic       timeout_hit_s;

  assign crc_d = next_crc8_d8(rx_data, crc_q);

`ifdef S3G_RX_TIMEOUT_EN
  // Fires on the cycle the gap counter would reach TIMEOUT_CYCLES.
  localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);

  logic [23:0] gap_q;

  assign timeout_hit_s = (state_q != S_IDLE) && !rx_valid && (gap_q == TIMEOUT_LAST);

  // Inter-byte gap counter: cleared by every byte, held at 0 while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap_q <= 24'd0;
    end else if (rx_valid || (state_q == S_IDLE) || timeout_hit_s) begin
      gap_q <= 24'd0;
    end else begin
      gap_q <= gap_q + 24'd1;
    end
  end
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Frame parser FSM with registered payload, status and strobe outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      len_q          <= 8'd0;
      byte_cnt_q     <= 4'd0;
      crc_q          <= 8'd0;
      payload_len_q  <= 8'd0;
      packet_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      err_crc_q      <= 1'b0;
      err_len_q      <= 1'b0;
      err_timeout_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        staging_q[i] <= 8'd0;
        buf_q[i]     <= 8'd0;
      end
    end else begin
      // Strobes default low so each lasts exactly one cycle.
      packet_valid_q <= 1'b0;
      err_crc_q      <= 1'b0;
      err_len_q      <= 1'b0;
      err_timeout_q  <= 1'b0;
      if (timeout_hit_s) begin
        state_q       <= S_IDLE;
        busy_q        <= 1'b0;
        err_timeout_q <= 1'b1;
      end else if (rx_valid) begin
        case (state_q)
          S_IDLE: begin
            // Anything but the start byte is line noise between frames.
            if (rx_data == SOF_BYTE) begin
              state_q <= S_LEN;
              busy_q  <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
          S_LEN: begin
            len_q      <= rx_data;
            crc_q      <= 8'd0;
            byte_cnt_q <= 4'd0;
            if (rx_data > MAX_LEN_B) begin
              err_len_q <= 1'b1;
              state_q   <= S_IDLE;
              busy_q    <= 1'b0;
            end else if (rx_data == 8'd0) begin
              state_q <= S_CRC;
            end else begin
              state_q <= S_DATA;
            end
          end
          S_DATA: begin
            staging_q[byte_cnt_q] <= rx_data;
            crc_q                 <= crc_d;
            byte_cnt_q            <= byte_cnt_q + 4'd1;
            if ({4'd0, byte_cnt_q} == (len_q - 8'd1)) begin
              state_q <= S_CRC;
            end else begin
              state_q <= S_DATA;
            end
          end
          S_CRC: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            if (rx_data == crc_q) begin
              packet_valid_q <= 1'b1;
              payload_len_q  <= len_q;
              // Staging may hold stale bytes from a longer earlier frame.
              for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= (8'(i) < len_q) ? staging_q[i] : 8'd0;
              end
            end else begin
              err_crc_q <= 1'b1;
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end else begin
        busy_q <= (state_q != S_IDLE);
      end
    end
  end

  assign packet_valid = packet_valid_q;
  assign payload_len  = payload_len_q;
  assign busy         = busy_q;
  assign err_crc      = err_crc_q;
  assign err_len      = err_len_q;
  assign err_timeout  = err_timeout_q;

  assign buf0  = buf_q[0];
  assign buf1  = buf_q[1];
  assign buf2  = buf_q[2];
  assign buf3  = buf_q[3];
  assign buf4  = buf_q[4];
  assign buf5  = buf_q[5];
  assign buf6  = buf_q[6];
  assign buf7  = buf_q[7];
  assign buf8  = buf_q[8];
  assign buf9  = buf_q[9];
  assign buf10 = buf_q[10];
  assign buf11 = buf_q[11];
  assign buf12 = buf_q[12];
  assign buf13 = buf_q[13];
  assign buf14 = buf_q[14];
  assign buf15 = buf_q[15];

endmodule
